// File: rtl/usb_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// usb_pingpong_buffer
//
// Two-bank packet buffer feeding the USB EP6 transmit controller. Image words
// from the frame path fill one bank while the controller drains the other.
// Each bank holds one USB packet (DEPTH words). A completed bank is presented
// first-word-fall-through on image_data, with ram_full high while it can be
// read.
//
// Optional feature macro: USB_PINGPONG_FLUSH_EN
//   When defined, a flush input exists. It pads a partially written bank
//   with PAD_WORD so that the bank completes and is sent.
//
// Ports
//   usb_clk        single clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   wr_data        image word from the frame path
//   wr_en          write strobe, honoured only while wr_ready=1
//   wr_ready       write bank can accept a word
//   frame_start    one-cycle pulse that discards all buffered data
//   fifo_image_en  consumer pops the current image_data word
//   image_data     current word of the read bank (FWFT)
//   ram_full       read bank holds a complete packet, image_data valid
//   pkt_done       one-cycle pulse, consumer finished the read bank
//   overflow_cnt   count of dropped writes (wr_en while wr_ready=0), saturating
//   underrun       sticky, fifo_image_en seen while ram_full=0
//   flush          (USB_PINGPONG_FLUSH_EN only) pad out the partial bank
// ---------------------------------------------------------------------------
module usb_pingpong_buffer #(
    parameter int                DATA_W   = 64,
    parameter int                DEPTH    = 64,
    parameter int                AW       = 6,
    parameter logic [DATA_W-1:0] PAD_WORD = {DATA_W{1'b1}}
) (
    input  logic              usb_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic              frame_start,
    input  logic              fifo_image_en,
    output logic [DATA_W-1:0] image_data,
    output logic              ram_full,
    input  logic              pkt_done,
    output logic [15:0]       overflow_cnt,
`ifdef USB_PINGPONG_FLUSH_EN
    input  logic              flush,
`endif
    output logic              underrun
);

    // Handshakes:
    //   Write side: a word transfers on a rising edge where wr_en=1 and
    //   wr_ready=1. wr_en with wr_ready=0 is dropped and counted in
    //   overflow_cnt. wr_ready depends only on internal state.
    //   Read side: ram_full acts as valid for image_data. A pop happens on a
    //   rising edge where fifo_image_en=1 and ram_full=1; the next word is on
    //   image_data one cycle later, so pops may be issued every cycle.
    //   fifo_image_en with ram_full=0 is ignored and sets underrun. pkt_done
    //   with ram_full=1 releases the bank; pkt_done otherwise is ignored.

    // Read-side FSM encoding
    localparam logic [1:0] R_IDLE = 2'd0;  // waiting for the read bank to fill
    localparam logic [1:0] R_PREF = 2'd1;  // word 0 read issued to the RAM
    localparam logic [1:0] R_RDY  = 2'd2;  // packet presented on image_data

    // Storage: bank select is the address MSB
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic [AW-1:0]     wr_ptr;
    logic              rd_bank;
    logic [AW-1:0]     rd_ptr;
    logic [1:0]        rd_state;
    logic              pad_mode;

    logic              wr_fire;
    logic              wr_last;
    logic [DATA_W-1:0] wr_word;
    logic              rd_release;
    logic              rd_pop;
    logic              rd_issue;
    logic [AW:0]       rd_addr;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    assign wr_ready = !full[wr_bank] && !pad_mode;
    assign ram_full = (rd_state == R_RDY);

    // frame_start overrides every other event in its cycle, including writes.
    assign wr_fire  = !frame_start && (pad_mode || (wr_en && wr_ready));
    assign wr_last  = wr_fire && (wr_ptr == AW'(DEPTH - 1));
    assign wr_word  = pad_mode ? PAD_WORD : wr_data;

    assign rd_release = !frame_start && (rd_state == R_RDY) && pkt_done;
    assign rd_pop     = !frame_start && (rd_state == R_RDY) && fifo_image_en && !pkt_done;

    // The RAM read is issued one cycle ahead of use: word 0 during R_PREF,
    // and the following word in the same cycle as each pop.
    assign rd_issue = (!frame_start && (rd_state == R_PREF)) || rd_pop;
    assign rd_addr  = {rd_bank, (rd_pop ? rd_ptr + AW'(1) : rd_ptr)};

    // The released bank is always the read bank and the completed bank is
    // always the write bank; the two are never the same bank in one cycle
    // because the write bank is never full while it is being written.
    always_comb begin
        full_nxt = full;
        if (rd_release) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // RAM: write port and registered read port
    // ---------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (wr_fire && !rst) begin
            mem[{wr_bank, wr_ptr}] <= wr_word;
        end
    end

    // image_data holds its value between reads; frame_start leaves it alone
    // because ram_full is low afterwards and it is not valid anyway.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            image_data <= '0;
        end else if (rd_issue) begin
            image_data <= mem[rd_addr];
        end
    end

    // ---------------------------------------------------------------------
    // Bank bookkeeping, write pointer and read FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (rst || frame_start) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            rd_bank  <= 1'b0;
            rd_ptr   <= '0;
            rd_state <= R_IDLE;
            underrun <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);  // wraps to 0 on the last word
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (fifo_image_en && (rd_state != R_RDY)) begin
                underrun <= 1'b1;
            end

            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= R_PREF;
                    end
                end
                R_PREF: begin
                    rd_state <= R_RDY;
                end
                R_RDY: begin
                    if (pkt_done) begin
                        rd_state <= R_IDLE;
                        rd_bank  <= ~rd_bank;
                        rd_ptr   <= '0;
                    end else if (fifo_image_en) begin
                        // Pops past the last word wrap and return stale data.
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Dropped-write counter; survives frame_start
    // ---------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (wr_en && !wr_ready && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Pad mode: fills the rest of a partial bank with PAD_WORD
    // ---------------------------------------------------------------------
`ifdef USB_PINGPONG_FLUSH_EN
    // A flush arriving with the write that completes the bank has nothing
    // left to pad, so wr_last takes precedence over entering pad mode.
    always_ff @(posedge usb_clk) begin
        if (rst || frame_start) begin
            pad_mode <= 1'b0;
        end else if (wr_last) begin
            pad_mode <= 1'b0;
        end else if (flush && !pad_mode && (wr_ptr != '0)) begin
            pad_mode <= 1'b1;
        end
    end
`else
    // Without flush a partial bank waits for more writes or frame_start.
    assign pad_mode = 1'b0;
`endif

endmodule

// File: tb/tb_usb_pingpong_buffer.sv
module tb_usb_pingpong_buffer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam logic [DATA_W-1:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic              usb_clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_en = 1'b0;
  logic              wr_ready;
  logic              frame_start = 1'b0;
  logic              fifo_image_en = 1'b0;
  logic [DATA_W-1:0] image_data;
  logic              ram_full;
  logic              pkt_done = 1'b0;
  logic [15:0]       overflow_cnt;
  logic              underrun;
`ifdef USB_PINGPONG_FLUSH_EN
  logic              flush = 1'b0;
`endif

  always #5 usb_clk = ~usb_clk;

  usb_pingpong_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .PAD_WORD (PAD)
  ) dut (
    .usb_clk       (usb_clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_ready      (wr_ready),
    .frame_start   (frame_start),
    .fifo_image_en (fifo_image_en),
    .image_data    (image_data),
    .ram_full      (ram_full),
    .pkt_done      (pkt_done),
    .overflow_cnt  (overflow_cnt),
`ifdef USB_PINGPONG_FLUSH_EN
    .flush         (flush),
`endif
    .underrun      (underrun)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packets are tracked as word queues plus the cycle each one completed.
  // A complete packet is presented 3 cycles after both its completion and
  // the release of the previous packet.
  logic [DATA_W-1:0] exp_q[$];   // words of complete, unreleased packets
  logic [DATA_W-1:0] part_q[$];  // words of the packet being assembled
  int                comp_q[$];  // completion cycle of each complete packet
  int                cyc = 0;
  int                rel_cyc = 0;
  int                rd_off = 0;
  logic [15:0]       m_ovf = '0;
  bit                m_und = 1'b0;
  bit                m_pad = 1'b0;
  bit                live = 1'b0;

  function automatic bit m_rf(input int k);
    int base;
    if (comp_q.size() == 0) return 1'b0;
    base = (comp_q[0] > rel_cyc) ? comp_q[0] : rel_cyc;
    return (k >= base + 3);
  endfunction

  function automatic bit m_wrr();
    return (comp_q.size() < 2) && !m_pad;
  endfunction

  initial begin : model_proc
    bit rf;
    bit wrr;
    int pre;
    forever begin
      @(posedge usb_clk);
      rf  = m_rf(cyc);
      wrr = m_wrr();
      if (rst) begin
        exp_q.delete(); part_q.delete(); comp_q.delete();
        rd_off = 0; rel_cyc = cyc; m_ovf = '0; m_und = 1'b0; m_pad = 1'b0;
        live = 1'b1;
      end else begin
        if (wr_en && !wrr && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        if (frame_start) begin
          exp_q.delete(); part_q.delete(); comp_q.delete();
          rd_off = 0; rel_cyc = cyc; m_und = 1'b0; m_pad = 1'b0;
        end else begin
          if (fifo_image_en && !rf) m_und = 1'b1;
          if (pkt_done && rf) begin
            for (int j = 0; j < DEPTH; j++) void'(exp_q.pop_front());
            void'(comp_q.pop_front());
            rel_cyc = cyc;
            rd_off  = 0;
          end else if (fifo_image_en && rf) begin
            rd_off = (rd_off + 1) % DEPTH;
          end
          pre = part_q.size();
          if (m_pad) part_q.push_back(PAD);
          else if (wr_en && wrr) part_q.push_back(wr_data);
          if (part_q.size() == DEPTH) begin
            for (int j = 0; j < DEPTH; j++) exp_q.push_back(part_q[j]);
            part_q.delete();
            comp_q.push_back(cyc);
            m_pad = 1'b0;
          end
`ifdef USB_PINGPONG_FLUSH_EN
          if (flush && !m_pad && pre != 0 && part_q.size() != 0) m_pad = 1'b1;
`endif
        end
      end
      cyc++;
    end
  end

  // ---------------- compare process (every cycle, at negedge) ----------------
  initial begin : compare_proc
    bit rf;
    forever begin
      @(negedge usb_clk);
      if (live) begin
        rf = m_rf(cyc);
        chk("wr_ready", 64'(wr_ready), 64'(m_wrr()));
        chk("ram_full", 64'(ram_full), 64'(rf));
        chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        chk("underrun", 64'(underrun), 64'(m_und));
        if (rf) chk("image_data", image_data, exp_q[rd_off]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the negedge; the DUT samples them on the next
  // posedge, and step() returns at the following negedge.
  task automatic step();
    @(posedge usb_clk);
    @(negedge usb_clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; fifo_image_en = 1'b0; pkt_done = 1'b0; frame_start = 1'b0;
`ifdef USB_PINGPONG_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = base + 64'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_rf(input int budget);
    int n = 0;
    while (!ram_full && n < budget) begin
      step(); n++;
    end
    if (!ram_full) chk("wait_ram_full_timeout", 64'(ram_full), 64'd1);
  endtask

  task automatic pop_pkt(input int gap_max);
    int cnt = 0;
    wait_rf(600);
    while (cnt < DEPTH) begin
      fifo_image_en = ($urandom_range(0, gap_max) == 0);
      if (fifo_image_en) cnt++;
      step();
    end
    fifo_image_en = 1'b0;
    pkt_done = 1'b1;
    step();
    pkt_done = 1'b0;
  endtask

  task automatic rand_writer(input int n);
    int cnt = 0;
    while (cnt < n) begin
      if (wr_ready && $urandom_range(0, 3) != 0) begin
        wr_en = 1'b1; wr_data = {$urandom, $urandom}; cnt++;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge usb_clk);
    do_reset();
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_ram_full", 64'(ram_full), 64'd0);
    chk("rst_image_data", image_data, 64'd0);
    chk("rst_overflow", 64'(overflow_cnt), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);

    // 1: one packet 0..63, exact ram_full latency, gapless readout
    write_words(64'd0, DEPTH);
    chk("t1_rf_plus1", 64'(ram_full), 64'd0);
    step();
    chk("t1_rf_plus2", 64'(ram_full), 64'd0);
    step();
    chk("t1_rf_plus3", 64'(ram_full), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t1_pop_word", image_data, 64'(i));
      fifo_image_en = 1'b1;
      step();
    end
    fifo_image_en = 1'b0;
    pkt_done = 1'b1; step(); pkt_done = 1'b0;
    chk("t1_rf_after_done", 64'(ram_full), 64'd0);

    // 2: both banks full, dropped writes, release frees the write bank
    do_reset();
    write_words(64'd1000, 2 * DEPTH);
    chk("t2_wr_ready_full", 64'(wr_ready), 64'd0);
    write_words(64'd5000, 5);
    chk("t2_overflow", 64'(overflow_cnt), 64'd5);
    wait_rf(10);
    chk("t2_first_word", image_data, 64'd1000);
    pkt_done = 1'b1; step(); pkt_done = 1'b0;
    chk("t2_wr_ready_freed", 64'(wr_ready), 64'd1);
    wait_rf(10);
    chk("t2_bank1_word0", image_data, 64'd1064);
    pop_pkt(0);

    // 3: continuous random traffic, four packets
    do_reset();
    fork
      rand_writer(4 * DEPTH);
      begin
        for (int p = 0; p < 4; p++) pop_pkt(2);
      end
    join
    chk("t3_overflow", 64'(overflow_cnt), 64'd0);

    // 4: pkt_done in the same cycle the other bank completes
    do_reset();
    write_words(64'd2000, DEPTH);
    wait_rf(10);
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_en = 1'b1; wr_data = 64'd2064 + 64'(i); fifo_image_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    step();
    fifo_image_en = 1'b0;
    wr_en = 1'b1; wr_data = 64'd2127; pkt_done = 1'b1;
    step();
    wr_en = 1'b0; pkt_done = 1'b0;
    chk("t4_rf_drop", 64'(ram_full), 64'd0);
    for (int n = 0; n < 3 && !ram_full; n++) step();
    chk("t4_rf_rerise", 64'(ram_full), 64'd1);
    chk("t4_bank1_word0", image_data, 64'd2064);
    pop_pkt(0);

    // 5: underrun, then frame_start mid-bank
    do_reset();
    fifo_image_en = 1'b1; step(); fifo_image_en = 1'b0;
    chk("t5_underrun_set", 64'(underrun), 64'd1);
    write_words(64'd300, 20);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("t5_underrun_clr", 64'(underrun), 64'd0);
    write_words(64'd500, DEPTH);
    wait_rf(10);
    chk("t5_first_word", image_data, 64'd500);
    pop_pkt(0);

`ifdef USB_PINGPONG_FLUSH_EN
    // 6: flush pads a partial bank
    do_reset();
    write_words(64'd3000, 10);
    flush = 1'b1; step(); flush = 1'b0;
    wait_rf(100);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t6_flush_word", image_data, (i < 10) ? 64'd3000 + 64'(i) : PAD);
      fifo_image_en = 1'b1;
      step();
    end
    fifo_image_en = 1'b0;
    pkt_done = 1'b1; step(); pkt_done = 1'b0;
`endif

    // 7: random mix of everything, checked by the model every cycle
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      wr_en         = ($urandom_range(0, 2) != 0);
      wr_data       = {$urandom, $urandom};
      fifo_image_en = ram_full ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      pkt_done      = ram_full ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 200) == 0);
      frame_start   = ($urandom_range(0, 400) == 0);
`ifdef USB_PINGPONG_FLUSH_EN
      flush         = ($urandom_range(0, 150) == 0);
`endif
      step();
    end
    wr_en = 1'b0; fifo_image_en = 1'b0; pkt_done = 1'b0; frame_start = 1'b0;
`ifdef USB_PINGPONG_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
